// File: rtl/freq_ctrl_pkg.sv
// Shared types and default constants for the resonant-drive frequency controller.
package freq_ctrl_pkg;

  // Controller FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_LOCK    = 2'd3
  } state_e;

  // Default geometry and tuning constants (50 MHz clock).
  localparam int unsigned F_W_DEF         = 20;
  localparam int unsigned ACC_W_DEF       = 28;
  localparam int unsigned F_START_DEF     = 214748;  // ~40 kHz
  localparam int unsigned F_MIN_DEF       = 161061;  // ~30 kHz
  localparam int unsigned F_MAX_DEF       = 268435;  // ~50 kHz
  localparam int unsigned STEP_COARSE_DEF = 500;
  localparam int unsigned STEP_FINE_DEF   = 50;
  localparam int unsigned SETTLE_CYC_DEF  = 1000;
  localparam int unsigned DEAD_CYC_DEF    = 8;

endpackage

// File: rtl/freq_ctrl_nco.sv
// Phase accumulator plus dead-time generator producing the complementary gate drive.
// The accumulator is never reloaded on a tuning-word change, so the output stays
// phase-continuous. Every phase edge (and every start from idle) forces both gates
// low for DEAD_CYC cycles before the new polarity is driven.
module nco_deadtime #(
  parameter int unsigned F_W      = 20,
  parameter int unsigned ACC_W    = 28,
  parameter int unsigned DEAD_CYC = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           run_i,
  input  logic [F_W-1:0] freq_i,
  output logic           drive_p_o,
  output logic           drive_n_o
);

  localparam int unsigned DW = $clog2(DEAD_CYC + 1);
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYC);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             phase_q, phase_d;
  logic [DW-1:0]    dead_q, dead_d;
  logic             drive_p_q, drive_p_d;
  logic             drive_n_q, drive_n_d;
  logic             phase_s;
  logic             edge_s;

  assign phase_s = acc_q[ACC_W-1];
  assign edge_s  = phase_s ^ phase_q;

  // Next-state for accumulator, edge tracker, dead-time counter and gate drives.
  always_comb begin
    acc_d     = acc_q;
    phase_d   = phase_q;
    dead_d    = dead_q;
    drive_p_d = 1'b0;
    drive_n_d = 1'b0;
    if (!run_i) begin
      // Idle: accumulator parked at zero, dead time pre-armed for the next start.
      acc_d   = '0;
      phase_d = 1'b0;
      dead_d  = DEAD_LOAD;
    end else begin
      acc_d   = acc_q + ACC_W'(freq_i);
      phase_d = phase_s;
      if (edge_s) begin
        // Any phase edge, even one inside the dead window, restarts the dead time.
        dead_d = DEAD_LOAD;
      end else if (dead_q != '0) begin
        dead_d = dead_q - DW'(1);
      end else begin
        drive_p_d = phase_s;
        drive_n_d = ~phase_s;
      end
    end
  end

  // NCO and gate-drive registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q     <= '0;
      phase_q   <= 1'b0;
      dead_q    <= DEAD_LOAD;
      drive_p_q <= 1'b0;
      drive_n_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      phase_q   <= phase_d;
      dead_q    <= dead_d;
      drive_p_q <= drive_p_d;
      drive_n_q <= drive_n_d;
    end
  end

  assign drive_p_o = drive_p_q;
  assign drive_n_o = drive_n_q;

endmodule

// File: rtl/freq_ctrl.sv
// Resonance-tracking frequency controller: owns the tuning word, steps it on each
// measurement verdict (coarse until the first direction reversal, fine afterwards),
// locks onto the reported best frequency, re-arms the measurement after the power
// stage settles, and drives the dead-timed complementary gate outputs.
module freq_ctrl
  import freq_ctrl_pkg::*;
#(
  parameter int unsigned F_W         = F_W_DEF,
  parameter int unsigned ACC_W       = ACC_W_DEF,
  parameter int unsigned F_START     = F_START_DEF,
  parameter int unsigned F_MIN       = F_MIN_DEF,
  parameter int unsigned F_MAX       = F_MAX_DEF,
  parameter int unsigned STEP_COARSE = STEP_COARSE_DEF,
  parameter int unsigned STEP_FINE   = STEP_FINE_DEF,
  parameter int unsigned SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int unsigned DEAD_CYC    = DEAD_CYC_DEF
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           enable_i,
  input  logic           freq_ready_i,
  input  logic           freq_set_up_down_i,
  input  logic           freq_opt_i,
  input  logic [F_W-1:0] best_freq_i,
  output logic [F_W-1:0] freq_o,
  output logic           data_start_o,
  output logic           locked_o,
  output logic           drive_p_o,
  output logic           drive_n_o
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_CYC);
  localparam logic [F_W-1:0]      F_START_W   = F_W'(F_START);
  localparam logic [F_W-1:0]      F_MIN_W     = F_W'(F_MIN);
  localparam logic [F_W-1:0]      F_MAX_W     = F_W'(F_MAX);
  localparam logic [F_W-1:0]      STEP_C_W    = F_W'(STEP_COARSE);
  localparam logic [F_W-1:0]      STEP_F_W    = F_W'(STEP_FINE);
  localparam logic signed [F_W:0] F_MIN_S     = $signed({1'b0, F_MIN_W});
  localparam logic signed [F_W:0] F_MAX_S     = $signed({1'b0, F_MAX_W});

  // Saturate a signed (F_W+1)-bit candidate into [F_MIN, F_MAX].
  function automatic logic [F_W-1:0] clamp_word(input logic signed [F_W:0] v);
    logic [F_W-1:0] r;
    if (v < F_MIN_S) begin
      r = F_MIN_W;
    end else if (v > F_MAX_S) begin
      r = F_MAX_W;
    end else begin
      r = v[F_W-1:0];
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [F_W-1:0]   freq_q, freq_d;
  logic             fine_q, fine_d;
  logic             last_dir_q, last_dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             data_start_q, data_start_d;
  logic             locked_q, locked_d;

  logic             settle_done_s;
  logic             reversal_s;
  logic             fine_step_s;
  logic [F_W-1:0]   step_s;
  logic signed [F_W:0] up_sum_s;
  logic signed [F_W:0] dn_sum_s;
  logic [F_W-1:0]   stepped_s;
  logic [F_W-1:0]   best_cl_s;
  logic             run_s;

  assign settle_done_s = (cnt_q == SETTLE_LAST);
  assign run_s         = (state_q != ST_IDLE);

  // Step candidate: the reversing step itself already uses the fine size.
  always_comb begin
    reversal_s  = (freq_set_up_down_i != last_dir_q);
    fine_step_s = fine_q | reversal_s;
    step_s      = fine_step_s ? STEP_F_W : STEP_C_W;
    up_sum_s    = $signed({1'b0, freq_q} + {1'b0, step_s});
    dn_sum_s    = $signed({1'b0, freq_q} - {1'b0, step_s});
    if (freq_set_up_down_i) begin
      stepped_s = clamp_word(up_sum_s);
    end else begin
      stepped_s = clamp_word(dn_sum_s);
    end
    best_cl_s = clamp_word($signed({1'b0, best_freq_i}));
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: disable overrides everything, including a coincident verdict.
  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_done_s) begin
            state_d = ST_MEASURE;
          end else begin
            state_d = ST_SETTLE;
          end
        end
        ST_MEASURE: begin
          if (freq_ready_i) begin
            state_d = freq_opt_i ? ST_LOCK : ST_SETTLE;
          end else begin
            state_d = ST_MEASURE;
          end
        end
        ST_LOCK: begin
          if (freq_ready_i && !freq_opt_i) begin
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_LOCK;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // FSM outputs and datapath next values (tuning word, step mode, settle counter).
  always_comb begin
    freq_d       = freq_q;
    fine_d       = fine_q;
    last_dir_d   = last_dir_q;
    cnt_d        = '0;
    data_start_d = 1'b0;
    locked_d     = locked_q;
    if (!enable_i) begin
      locked_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          freq_d   = F_START_W;
          fine_d   = 1'b0;
          locked_d = 1'b0;
        end
        ST_SETTLE: begin
          locked_d = 1'b0;
          if (settle_done_s) begin
            data_start_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_MEASURE, ST_LOCK: begin
          if (freq_ready_i && freq_opt_i) begin
            freq_d   = best_cl_s;
            locked_d = 1'b1;
          end else if (freq_ready_i) begin
            freq_d     = stepped_s;
            fine_d     = fine_step_s;
            last_dir_d = freq_set_up_down_i;
            locked_d   = 1'b0;
          end else begin
            locked_d = locked_q;
          end
        end
        default: begin
          locked_d = 1'b0;
        end
      endcase
    end
  end

  // Datapath and registered-output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      freq_q       <= F_START_W;
      fine_q       <= 1'b0;
      last_dir_q   <= 1'b1;
      cnt_q        <= '0;
      data_start_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      freq_q       <= freq_d;
      fine_q       <= fine_d;
      last_dir_q   <= last_dir_d;
      cnt_q        <= cnt_d;
      data_start_q <= data_start_d;
      locked_q     <= locked_d;
    end
  end

  nco_deadtime #(
    .F_W      (F_W),
    .ACC_W    (ACC_W),
    .DEAD_CYC (DEAD_CYC)
  ) u_nco (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .run_i     (run_s),
    .freq_i    (freq_q),
    .drive_p_o (drive_p_o),
    .drive_n_o (drive_n_o)
  );

  assign freq_o       = freq_q;
  assign data_start_o = data_start_q;
  assign locked_o     = locked_q;

endmodule

// File: tb/tb_freq_ctrl.sv
// Self-checking bench for freq_ctrl: verdict table with a scoreboard queue, plus
// hand sequences for settle timing, clamping, enable/reset corner cases and drive.
module tb_freq_ctrl;

  localparam int SETTLE = 1000;
  localparam int DEAD   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        freq_ready = 1'b0;
  logic        up = 1'b0;
  logic        opt = 1'b0;
  logic [19:0] best = 20'd0;
  logic [19:0] freq_o;
  logic        data_start_o, locked_o, drive_p_o, drive_n_o;

  freq_ctrl dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .enable_i           (enable),
    .freq_ready_i       (freq_ready),
    .freq_set_up_down_i (up),
    .freq_opt_i         (opt),
    .best_freq_i        (best),
    .freq_o             (freq_o),
    .data_start_o       (data_start_o),
    .locked_o           (locked_o),
    .drive_p_o          (drive_p_o),
    .drive_n_o          (drive_n_o)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Output monitors, sampled on the falling edge.
  int  ds_count = 0;
  bit  ovl_seen = 1'b0;
  int  low_run = 0;
  int  min_gap = 1000000;
  bit  prev_p = 1'b0;
  bit  meas_on = 1'b0;
  int  last_rise = -1;
  int  n_periods = 0;
  int  bad_periods = 0;
  int  per_lo = 0;
  int  per_hi = 0;

  always @(negedge clk) begin
    if (data_start_o) ds_count++;
    if (drive_p_o && drive_n_o) ovl_seen = 1'b1;
    if (drive_p_o || drive_n_o) begin
      if (low_run > 0 && low_run < min_gap) min_gap = low_run;
      low_run = 0;
    end else begin
      low_run++;
    end
    if (meas_on && drive_p_o && !prev_p) begin
      if (last_rise >= 0) begin
        n_periods++;
        if ((cyc - last_rise) < per_lo || (cyc - last_rise) > per_hi) bad_periods++;
      end
      last_rise = cyc;
    end
    prev_p = drive_p_o;
  end

  typedef struct {
    logic [19:0] f;
    bit          l;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    bit          u;
    bit          o;
    logic [19:0] b;
    logic [19:0] ef;
    bit          el;
    bit          eds;
  } vec_t;
  vec_t vecs[6];

  // Drive enable; returns the cycle stamp of the edge that sampled it.
  task automatic set_enable(input bit v, output int start);
    @(negedge clk);
    enable = v;
    @(negedge clk);
    start = cyc;
  endtask

  // One-cycle verdict; expectation queued on drive, compared when freq updates.
  task automatic send_verdict(input string name, input bit u, input bit o, input logic [19:0] b,
                              input logic [19:0] ef, input bit el, output int start);
    exp_t e;
    @(negedge clk);
    freq_ready = 1'b1;
    up = u;
    opt = o;
    best = b;
    sb_q.push_back('{ef, el});
    @(negedge clk);
    freq_ready = 1'b0;
    start = cyc;
    e = sb_q.pop_front();
    check({name, "_freq"}, freq_o, e.f);
    check({name, "_locked"}, locked_o, e.l);
  endtask

  // data_start must appear SETTLE+1 cycles after the triggering edge, one cycle wide.
  task automatic wait_ds(input string name, input int start);
    int seen = 0;
    for (int i = 0; i < SETTLE + 100 && seen == 0; i++) begin
      @(negedge clk);
      if (data_start_o) seen = cyc;
    end
    check({name, "_ds_delay"}, seen - start, SETTLE + 1);
    @(negedge clk);
    check({name, "_ds_width"}, data_start_o, 0);
  endtask

  task automatic expect_no_ds(input string name);
    int c0 = ds_count;
    repeat (SETTLE + 20) @(negedge clk);
    check({name, "_no_ds"}, ds_count - c0, 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, st2, lat;
    real ep;

    vecs[0] = '{1'b1, 1'b0, 20'd0,      20'd215248, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 20'd0,      20'd215198, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 20'd0,      20'd215148, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 20'd215000, 20'd215000, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 20'd100000, 20'd161061, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 20'd0,      20'd161111, 1'b0, 1'b1};

    // Reset values.
    #5 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_freq", freq_o, 214748);
    check("rst_ds", data_start_o, 0);
    check("rst_locked", locked_o, 0);
    check("rst_drive_p", drive_p_o, 0);
    check("rst_drive_n", drive_n_o, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Enable, gate latency, stale verdict in SETTLE, first data_start.
    set_enable(1'b1, st);
    check("en_freq", freq_o, 214748);
    lat = 0;
    for (int i = 1; i <= 30 && lat == 0; i++) begin
      if (drive_p_o || drive_n_o) lat = i;
      else @(negedge clk);
    end
    check("gate_latency_ge9", (lat >= DEAD + 1) ? 1 : 0, 1);
    repeat (400) @(negedge clk);
    send_verdict("stale", 1'b1, 1'b0, 20'd0, 20'd214748, 1'b0, st2);
    wait_ds("first", st);

    // Verdict table.
    for (int i = 0; i < 6; i++) begin
      send_verdict($sformatf("vec%0d", i), vecs[i].u, vecs[i].o, vecs[i].b, vecs[i].ef, vecs[i].el, st);
      if (vecs[i].eds) wait_ds($sformatf("vec%0d", i), st);
      else expect_no_ds($sformatf("vec%0d", i));
    end

    // Upper clamp with a coarse step.
    @(negedge clk) enable = 1'b0;
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    set_enable(1'b1, st);
    wait_ds("c_up", st);
    send_verdict("c_up_lock", 1'b0, 1'b1, 20'd268335, 20'd268335, 1'b1, st);
    send_verdict("c_up_step", 1'b1, 1'b0, 20'd0, 20'd268435, 1'b0, st);
    wait_ds("c_up_step", st);

    // Disable holds freq and stops the gates; re-enable reloads the start word.
    set_enable(1'b0, st);
    check("dis_freq", freq_o, 268435);
    check("dis_locked", locked_o, 0);
    @(negedge clk);
    check("dis_gates", {drive_p_o, drive_n_o}, 0);
    set_enable(1'b1, st);
    check("reen_freq", freq_o, 214748);
    wait_ds("reen", st);
    send_verdict("rev_dn", 1'b0, 1'b0, 20'd0, 20'd214698, 1'b0, st);
    wait_ds("rev_dn", st);

    // IDLE clears fine mode: coarse down steps, the second one clamps at F_MIN.
    set_enable(1'b0, st);
    set_enable(1'b1, st);
    wait_ds("c_dn", st);
    send_verdict("c_dn_lock", 1'b0, 1'b1, 20'd161600, 20'd161600, 1'b1, st);
    send_verdict("c_dn_step1", 1'b0, 1'b0, 20'd0, 20'd161100, 1'b0, st);
    wait_ds("c_dn_step1", st);
    send_verdict("c_dn_step2", 1'b0, 1'b0, 20'd0, 20'd161061, 1'b0, st);
    wait_ds("c_dn_step2", st);

    // Enable drop coincident with a verdict: disable wins.
    @(negedge clk);
    enable = 1'b0;
    freq_ready = 1'b1;
    up = 1'b1;
    opt = 1'b0;
    @(negedge clk);
    freq_ready = 1'b0;
    check("coinc_freq", freq_o, 161061);
    check("coinc_locked", locked_o, 0);
    @(negedge clk);
    check("coinc_gates", {drive_p_o, drive_n_o}, 0);
    expect_no_ds("coinc");

    // Asynchronous reset while locked: outputs clear without a clock edge.
    set_enable(1'b1, st);
    wait_ds("ar", st);
    send_verdict("ar_lock", 1'b0, 1'b1, 20'd230000, 20'd230000, 1'b1, st);
    repeat (700) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("ar_freq", freq_o, 214748);
    check("ar_locked", locked_o, 0);
    check("ar_ds", data_start_o, 0);
    check("ar_gates", {drive_p_o, drive_n_o}, 0);
    enable = 1'b0;
    @(negedge clk) rst = 1'b0;

    // Drive waveform at a locked frequency.
    set_enable(1'b1, st);
    wait_ds("drv", st);
    send_verdict("drv_lock", 1'b0, 1'b1, 20'd200000, 20'd200000, 1'b1, st);
    ep = 268435456.0 / 200000.0;
    per_lo = int'($ceil(ep - 1.0));
    per_hi = int'($floor(ep + 1.0));
    meas_on = 1'b1;
    repeat (15000) @(negedge clk);
    meas_on = 1'b0;
    check("drv_period_count_ge8", (n_periods >= 8) ? 1 : 0, 1);
    check("drv_bad_periods", bad_periods, 0);
    check("drv_overlap", ovl_seen, 0);
    check("drv_min_gap_ok", (min_gap >= DEAD && min_gap < 100) ? 1 : 0, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
